// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Controller operating states.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DMEM_WAIT  = 2'd1,
    HALT_DRAIN = 2'd2,
    HALTED     = 2'd3
  } ctrl_state_t;

  // Number of non-frozen cycles needed for HLT to retire through WB.
  localparam int HALT_DRAIN_CYC = 3;

  // Control bundle for the PC and the four pipe registers.
  typedef struct packed {
    logic pc_wen;
    logic ifid_wen;
    logic idex_wen;
    logic exmem_wen;
    logic memwb_wen;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } pipe_ctrl_t;

  // Everything advances, nothing cleared.
  localparam pipe_ctrl_t CTRL_ADVANCE = 9'b1_1111_0000;
  // Whole pipe frozen, bubble injected into WB.
  localparam pipe_ctrl_t CTRL_FREEZE  = 9'b0_0000_0001;
  // Core stopped: nothing written, nothing cleared.
  localparam pipe_ctrl_t CTRL_STOP    = 9'b0_0000_0000;
  // Held in reset: nothing written, everything cleared.
  localparam pipe_ctrl_t CTRL_RESET   = 9'b0_0000_1111;

  // States in which PC stalls are counted as performance events.
  function automatic logic is_run_state(input ctrl_state_t s);
    return (s == RUN) || (s == DMEM_WAIT);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard decode: load-use, data-memory wait, instruction-memory wait.
module hazard_detect #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             imem_ready,
  input  logic             exmem_req,
  input  logic             dmem_ready,
  output logic             load_use,
  output logic             dmem_wait,
  output logic             imem_wait
);

  logic rs_hit;
  logic rt_hit;

  // r0 is hardwired to zero, so a load into it never creates a dependency.
  assign rs_hit    = (idex_rd == ifid_rs);
  assign rt_hit    = ifid_uses_rt & (idex_rd == ifid_rt);
  assign load_use  = idex_memread & (idex_rd != {REG_W{1'b0}}) & (rs_hit | rt_hit);
  assign dmem_wait = exmem_req & ~dmem_ready;
  assign imem_wait = ~imem_ready;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: hazard priority, stall/flush generation, halt and
// data-memory timeout sequencing, stall-cycle performance counter.
module pipe_hazard_ctrl #(
  parameter int REG_W       = 4,
  parameter int TIMEOUT     = 255,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_W-1:0]       ifid_rs,
  input  logic [REG_W-1:0]       ifid_rt,
  input  logic                   ifid_uses_rt,
  input  logic                   ifid_halt,
  input  logic                   idex_memread,
  input  logic [REG_W-1:0]       idex_rd,
  input  logic                   br_taken_ex,
  input  logic                   imem_ready,
  input  logic                   exmem_req,
  input  logic                   dmem_ready,
  output logic                   pc_wen,
  output logic                   ifid_wen,
  output logic                   idex_wen,
  output logic                   exmem_wen,
  output logic                   memwb_wen,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic                   memwb_flush,
  output logic                   halted,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  import pipe_ctrl_pkg::*;

  localparam int WAIT_W  = $clog2(TIMEOUT + 1);
  localparam int DRAIN_W = 2;
  localparam logic [WAIT_W-1:0]  TIMEOUT_V = WAIT_W'(TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_V   = DRAIN_W'(HALT_DRAIN_CYC);

  ctrl_state_t            state_r;
  ctrl_state_t            state_nxt;
  logic [WAIT_W-1:0]      wait_cnt_r;
  logic [WAIT_W-1:0]      wait_nxt;
  logic [DRAIN_W-1:0]     drain_cnt_r;
  logic [DRAIN_W-1:0]     drain_nxt;
  logic                   mem_err_r;
  logic                   halted_r;
  logic                   set_err;
  logic                   set_halt;
  logic [STALL_CNT_W-1:0] stall_cnt_r;
  logic                   stall_inc;
  logic                   load_use;
  logic                   dmem_wait;
  logic                   imem_wait;
  pipe_ctrl_t             ctrl_s;
  pipe_ctrl_t             ctrl_out;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .imem_ready   (imem_ready),
    .exmem_req    (exmem_req),
    .dmem_ready   (dmem_ready),
    .load_use     (load_use),
    .dmem_wait    (dmem_wait),
    .imem_wait    (imem_wait)
  );

  // Next-state, counter updates and prioritised stall/flush controls.
  always_comb begin
    ctrl_s    = CTRL_ADVANCE;
    state_nxt = state_r;
    wait_nxt  = wait_cnt_r;
    drain_nxt = drain_cnt_r;
    set_err   = 1'b0;
    set_halt  = 1'b0;
    case (state_r)
      RUN, DMEM_WAIT: begin
        if (dmem_wait) begin
          // Data memory stall freezes everything and overrides all other hazards.
          ctrl_s = CTRL_FREEZE;
          if (state_r == RUN) begin
            wait_nxt = WAIT_W'(1);
          end else begin
            wait_nxt = wait_cnt_r + WAIT_W'(1);
          end
          if (wait_nxt >= TIMEOUT_V) begin
            state_nxt = HALTED;
            set_err   = 1'b1;
          end else begin
            state_nxt = DMEM_WAIT;
          end
        end else begin
          wait_nxt  = {WAIT_W{1'b0}};
          state_nxt = RUN;
          if (br_taken_ex) begin
            // Squash the two wrong-path instructions; PC takes the target.
            ctrl_s.ifid_flush = 1'b1;
            ctrl_s.idex_flush = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID one cycle, bubble into EX.
            ctrl_s.pc_wen     = 1'b0;
            ctrl_s.ifid_wen   = 1'b0;
            ctrl_s.idex_flush = 1'b1;
          end else begin
            if (imem_wait | ifid_halt) begin
              ctrl_s.pc_wen     = 1'b0;
              ctrl_s.ifid_flush = 1'b1;
            end else begin
              ctrl_s = CTRL_ADVANCE;
            end
            // HLT blocked by a load-use stays in ID and is taken on the retry.
            if (ifid_halt) begin
              state_nxt = HALT_DRAIN;
              drain_nxt = {DRAIN_W{1'b0}};
            end else begin
              state_nxt = RUN;
            end
          end
        end
      end
      HALT_DRAIN: begin
        if (dmem_wait) begin
          ctrl_s = CTRL_FREEZE;
        end else begin
          ctrl_s.pc_wen     = 1'b0;
          ctrl_s.ifid_flush = 1'b1;
          drain_nxt         = drain_cnt_r + DRAIN_W'(1);
          if (drain_nxt == DRAIN_V) begin
            state_nxt = HALTED;
            set_halt  = 1'b1;
          end else begin
            state_nxt = HALT_DRAIN;
          end
        end
      end
      HALTED: begin
        ctrl_s = CTRL_STOP;
      end
      default: begin
        ctrl_s    = CTRL_FREEZE;
        state_nxt = RUN;
      end
    endcase
  end

  assign stall_inc = is_run_state(state_r) & ~ctrl_s.pc_wen;

  // While reset is held the pipe is frozen and fully cleared.
  assign ctrl_out    = rst_n ? ctrl_s : CTRL_RESET;
  assign pc_wen      = ctrl_out.pc_wen;
  assign ifid_wen    = ctrl_out.ifid_wen;
  assign idex_wen    = ctrl_out.idex_wen;
  assign exmem_wen   = ctrl_out.exmem_wen;
  assign memwb_wen   = ctrl_out.memwb_wen;
  assign ifid_flush  = ctrl_out.ifid_flush;
  assign idex_flush  = ctrl_out.idex_flush;
  assign exmem_flush = ctrl_out.exmem_flush;
  assign memwb_flush = ctrl_out.memwb_flush;
  assign halted      = halted_r;
  assign mem_err     = mem_err_r;
  assign stall_cnt   = stall_cnt_r;

  // Controller state and wait/drain counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      drain_cnt_r <= {DRAIN_W{1'b0}};
    end else begin
      state_r     <= state_nxt;
      wait_cnt_r  <= wait_nxt;
      drain_cnt_r <= drain_nxt;
    end
  end

  // Sticky status flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err_r <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      if (set_err) begin
        mem_err_r <= 1'b1;
      end
      if (set_halt) begin
        halted_r <= 1'b1;
      end
    end
  end

  // Saturating count of PC-stall cycles while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (stall_inc && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
    end
  end

endmodule
